// File: rtl/regfile_param.sv
// Parametrised register file: synchronous write, registered dual read with valid strobe,
// and a post-reset clear sweep. Optional same-edge write forwarding via WRITE_BYPASS_EN.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_read1,
   output logic [DATA_W-1:0] data_read2,
   output logic              rd_valid,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] data_write,
   input  logic              reg_write,
   output logic              ready,
   output logic              wr_drop
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              rd_valid_q;
   logic              wr_drop_q;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] regs_q [DEPTH];

   logic [ADDR_W-1:0] rd_addr [2];
   logic              run;

   assign run   = (state_q == ST_RUN);
   assign ready = run;

   // Clear pointer wraps back to 0 on the same edge that enters RUN.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == ST_CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_ptr_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         rd_valid_q <= rd_en && run;
         wr_drop_q  <= reg_write && !run;
      end
   end

   // Single array write port shared by the clear sweep and user writes.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
         end else if (reg_write && !((ZERO_REG != 0) && (write_reg == '0))) begin
            mem_we    = 1'b1;
            mem_waddr = write_reg;
            mem_wdata = data_write;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         regs_q[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_addr[0] = read_reg1;
   assign rd_addr[1] = read_reg2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic              addr_zero;
         logic [DATA_W-1:0] rd_word;
         logic [DATA_W-1:0] rd_data_q;

         assign addr_zero = (ZERO_REG != 0) && (rd_addr[gi] == '0);
`ifdef WRITE_BYPASS_EN
         assign rd_word = addr_zero ? '0 :
                          (reg_write && (write_reg == rd_addr[gi])) ? data_write :
                          regs_q[rd_addr[gi]];
`else
         assign rd_word = addr_zero ? '0 : regs_q[rd_addr[gi]];
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_q <= '0;
            end else if (rd_en && run) begin
               rd_data_q <= rd_word;
            end
         end
      end
   endgenerate

   assign data_read1 = g_rd[0].rd_data_q;
   assign data_read2 = g_rd[1].rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build, ZERO_REG=0 variant, and a 16-bit x 8 variant.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  rr1 = '0;
   logic [4:0]  rr2 = '0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;

   logic [31:0] d1, d2, d1_nz, d2_nz;
   logic [15:0] d1_s, d2_s;
   logic        vld, rdy, drop, vld_nz, rdy_nz, drop_nz, vld_s, rdy_s, drop_s;

   int n_total = 0;
   int n_bad   = 0;

`ifdef WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   regfile_param dut (
      .clk(clk), .rst(rst), .read_reg1(rr1), .read_reg2(rr2), .rd_en(rd_en),
      .data_read1(d1), .data_read2(d2), .rd_valid(vld), .write_reg(wa),
      .data_write(wd), .reg_write(reg_write), .ready(rdy), .wr_drop(drop)
   );

   regfile_param #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .read_reg1(rr1), .read_reg2(rr2), .rd_en(rd_en),
      .data_read1(d1_nz), .data_read2(d2_nz), .rd_valid(vld_nz), .write_reg(wa),
      .data_write(wd), .reg_write(reg_write), .ready(rdy_nz), .wr_drop(drop_nz)
   );

   regfile_param #(.DATA_W(16), .ADDR_W(3)) dut_s (
      .clk(clk), .rst(rst), .read_reg1(rr1[2:0]), .read_reg2(rr2[2:0]), .rd_en(rd_en),
      .data_read1(d1_s), .data_read2(d2_s), .rd_valid(vld_s), .write_reg(wa[2:0]),
      .data_write(wd[15:0]), .reg_write(reg_write), .ready(rdy_s), .wr_drop(drop_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] e1, e2;

      // reset state
      tick();
      tick();
      chk("rst_ready", {31'd0, rdy}, 32'd0);
      chk("rst_valid", {31'd0, vld}, 32'd0);
      chk("rst_drop",  {31'd0, drop}, 32'd0);
      chk("rst_d1", d1, 32'd0);
      chk("rst_d2", d2, 32'd0);
      rst = 1'b0;

      // clear sweep with a dropped write on cycle 10
      for (int i = 1; i <= 32; i++) begin
         if (i == 10) begin
            reg_write = 1'b1; wa = 5'd3; wd = 32'hAAAA5555;
         end
         tick();
         if (i == 10) begin
            chk("clr_drop", {31'd0, drop}, 32'd1);
            chk("clr_drop_small_ready", {31'd0, drop_s}, 32'd0);
            reg_write = 1'b0;
         end
         if (i == 11) chk("clr_drop_pulse_end", {31'd0, drop}, 32'd0);
         if (i == 7)  chk("small_clr_busy", {31'd0, rdy_s}, 32'd0);
         if (i == 8)  chk("small_clr_done", {31'd0, rdy_s}, 32'd1);
         if (i < 32)  chk("clr_busy", {31'd0, rdy}, 32'd0);
      end
      chk("clr_done", {31'd0, rdy}, 32'd1);
      chk("clr_done_nz", {31'd0, rdy_nz}, 32'd1);

      // every entry reads back zero, including the dropped address 3
      for (int a = 1; a <= 31; a++) begin
         rd_en = 1'b1; rr1 = 5'(a); rr2 = 5'(32 - a);
         tick();
         chk("idle_valid", {31'd0, vld}, 32'd1);
         chk("idle_d1", d1, 32'd0);
         chk("idle_d2", d2, 32'd0);
      end
      rd_en = 1'b0;
      tick();
      chk("idle_valid_off", {31'd0, vld}, 32'd0);

      // write then read same entry on both ports
      reg_write = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      tick();
      reg_write = 1'b0; rd_en = 1'b1; rr1 = 5'd5; rr2 = 5'd5;
      tick();
      chk("wr_valid", {31'd0, vld}, 32'd1);
      chk("wr_d1", d1, 32'hDEADBEEF);
      chk("wr_d2", d2, 32'hDEADBEEF);
      chk("wr_small_d1", {16'd0, d1_s}, 32'h0000BEEF);
      chk("wr_small_d2", {16'd0, d2_s}, 32'h0000BEEF);
      rd_en = 1'b0; rr1 = 5'd0;
      tick();
      chk("hold_valid", {31'd0, vld}, 32'd0);
      chk("hold_d1", d1, 32'hDEADBEEF);
      chk("hold_small_d1", {16'd0, d1_s}, 32'h0000BEEF);

      // zero register
      reg_write = 1'b1; wa = 5'd0; wd = 32'h12345678;
      tick();
      chk("zero_no_drop", {31'd0, drop}, 32'd0);
      reg_write = 1'b0; rd_en = 1'b1; rr1 = 5'd0; rr2 = 5'd0;
      tick();
      chk("zero_d1", d1, 32'd0);
      chk("zero_d2", d2, 32'd0);
      chk("zero_small_d1", {16'd0, d1_s}, 32'd0);
      chk("nz_d1", d1_nz, 32'h12345678);
      chk("nz_d2", d2_nz, 32'h12345678);
      rd_en = 1'b0;

      // same-edge collision on address 7
      reg_write = 1'b1; wa = 5'd7; wd = 32'h11111111;
      tick();
      wd = 32'h22222222; rd_en = 1'b1; rr1 = 5'd7; rr2 = 5'd5;
      tick();
      e1 = BYP ? 32'h22222222 : 32'h11111111;
      chk("coll_d1", d1, e1);
      chk("coll_d2", d2, 32'hDEADBEEF);
      chk("coll_small_d1", {16'd0, d1_s}, {16'd0, e1[15:0]});
      reg_write = 1'b0;
      tick();
      chk("coll_after_d1", d1, 32'h22222222);
      rd_en = 1'b0;

      // reset on clear cycle 20 restarts the full sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 19; i++) tick();
      chk("mid_busy", {31'd0, rdy}, 32'd0);
      rst = 1'b1;
      tick();
      chk("mid_rst_ready", {31'd0, rdy}, 32'd0);
      chk("mid_rst_small_ready", {31'd0, rdy_s}, 32'd0);
      rst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 8)  chk("mid_small_done", {31'd0, rdy_s}, 32'd1);
         if (i == 31) chk("mid_busy_31", {31'd0, rdy}, 32'd0);
      end
      chk("mid_done", {31'd0, rdy}, 32'd1);
      rd_en = 1'b1; rr1 = 5'd5; rr2 = 5'd7;
      tick();
      chk("mid_cleared_d1", d1, 32'd0);
      chk("mid_cleared_d2", d2, 32'd0);
      chk("mid_cleared_small", {16'd0, d1_s}, 32'd0);
      rd_en = 1'b0;

      // 16-bit x 8 sweep
      for (int a = 0; a < 8; a++) begin
         reg_write = 1'b1; wa = 5'(a); wd = 32'hF00D0000 | (32'(a) * 32'h1111);
         tick();
      end
      reg_write = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd_en = 1'b1; rr1 = 5'(a); rr2 = 5'(7 - a);
         tick();
         e1 = (a == 0) ? 32'd0 : 32'(a) * 32'h1111;
         e2 = (a == 7) ? 32'd0 : 32'(7 - a) * 32'h1111;
         chk("sweep_small_d1", {16'd0, d1_s}, e1);
         chk("sweep_small_d2", {16'd0, d2_s}, e2);
         chk("sweep_d1", d1, (a == 0) ? 32'd0 : (32'hF00D0000 | e1));
      end
      rd_en = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
